// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared constants, encodings and decode helper for the load/store unit
//
// Package lsu_pkg
//   XLEN               : data/address width (only 32 is supported)
//   OP_LOAD / OP_STORE : RV32I major opcodes handled by the unit
//   funct3_e           : access size/sign encodings (LB..LHU, with SB..SW aliases)
//   state_e            : access FSM states
//   access_bad()       : 1 when an access must fault (illegal funct3 or misaligned)

package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [2:0] {
    F3_LB  = 3'd0,
    F3_LH  = 3'd1,
    F3_LW  = 3'd2,
    F3_LBU = 3'd4,
    F3_LHU = 3'd5
  } funct3_e;

  // Stores share the byte/half/word encodings of the signed loads.
  localparam funct3_e F3_SB = F3_LB;
  localparam funct3_e F3_SH = F3_LH;
  localparam funct3_e F3_SW = F3_LW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // funct3[1:0] carries the access size for every legal encoding, so the
  // alignment rule can be applied before the legality check is known.
  function automatic logic access_bad(logic is_store, logic [2:0] f3, logic [1:0] off);
    logic legal;
    logic aligned;
    case (f3)
      F3_LB, F3_LH, F3_LW: legal = 1'b1;
      F3_LBU, F3_LHU:      legal = !is_store;
      default:             legal = 1'b0;
    endcase
    case (f3[1:0])
      2'b01:   aligned = !off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b1;
    endcase
    return !(legal && aligned);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory req/gnt + rvalid port bundle
//
// Signals
//   mem_req    : request, held until mem_gnt
//   mem_we     : 1 = write
//   mem_addr   : word address (low two bits zero)
//   mem_wdata  : lane-replicated store data
//   mem_wstrb  : byte enables (0 on loads)
//   mem_gnt    : request accepted this cycle
//   mem_rvalid : read data valid
//   mem_rdata  : read word
// Modports: master (load/store unit side), slave (memory side)

interface load_store_unit_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  mem_req;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_gnt;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/load_store_unit_align.sv
// rtl/load_store_unit_align.sv - byte-lane steering for stores and extraction/extension for loads
//
// Module lsu_align (purely combinational)
//   st_funct3, st_offset, st_data : store size, byte offset and rs2 value
//   st_wstrb, st_wdata            : byte enables and lane-replicated write data
//   ld_funct3, ld_offset, ld_rdata: load size/sign, byte offset and raw memory word
//   ld_data                       : right-justified, sign/zero-extended load result

module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      st_funct3,
  input  logic [1:0]      st_offset,
  input  logic [XLEN-1:0] st_data,
  output logic [3:0]      st_wstrb,
  output logic [XLEN-1:0] st_wdata,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_offset,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [XLEN-1:0] ld_data
);

  logic [XLEN-1:0] ld_shifted;

  // Replicating the narrow datum into every lane lets the strobes alone pick
  // the destination bytes, so no store-side shifter is needed.
  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = st_data;
    case (st_funct3)
      F3_SB: begin
        st_wstrb = 4'b0001 << st_offset;
        st_wdata = {4{st_data[7:0]}};
      end
      F3_SH: begin
        st_wstrb = 4'b0011 << st_offset;
        st_wdata = {2{st_data[15:0]}};
      end
      F3_SW: begin
        st_wstrb = 4'b1111;
      end
      default: begin
        st_wstrb = 4'b0000;
      end
    endcase
  end

  assign ld_shifted = ld_rdata >> {ld_offset, 3'b000};

  always_comb begin
    ld_data = '0;
    case (ld_funct3)
      F3_LB:   ld_data = {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      F3_LH:   ld_data = {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      F3_LW:   ld_data = ld_shifted;
      F3_LBU:  ld_data = {24'h000000, ld_shifted[7:0]};
      F3_LHU:  ld_data = {16'h0000, ld_shifted[15:0]};
      default: ld_data = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle RV32I load/store stage with req/gnt + rvalid memory port
//
// Module load_store_unit
//   clk, rst_n        : clock, asynchronous active-low reset
//   valid_in          : instruction presented (sampled only while idle)
//   opcode, funct3    : instruction fields selecting load/store and size/sign
//   addr, store_data  : effective address (ALU result) and rs2 value
//   rd_in / rd_out    : destination register, returned with done
//   busy              : access in flight; the core holds the instruction
//   done, fault       : one-cycle completion pulse, fault qualifies it
//   load_data         : extended load result (0 after stores and faults)
//   mem               : data-memory port (master side)

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int OPCODE_WIDTH = 7,
  parameter int FUNCT3_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [FUNCT3_WIDTH-1:0] funct3,
  input  logic [DATA_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH-1:0]   store_data,
  input  logic [4:0]              rd_in,
  output logic                    busy,
  output logic                    done,
  output logic                    fault,
  output logic [DATA_WIDTH-1:0]   load_data,
  output logic [4:0]              rd_out,
  load_store_unit_if.master       mem
);

  state_e state_q;
  state_e state_d;

  logic                    is_load;
  logic                    is_store;
  logic                    accept;
  logic                    bad;

  logic [DATA_WIDTH-1:0]   addr_q;
  logic [FUNCT3_WIDTH-1:0] f3_q;
  logic [4:0]              rd_q;
  logic                    we_q;
  logic                    fault_q;
  logic [3:0]              wstrb_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   load_data_q;

  logic [3:0]              st_wstrb;
  logic [DATA_WIDTH-1:0]   st_wdata;
  logic [DATA_WIDTH-1:0]   ld_ext;

  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign accept   = (state_q == ST_IDLE) && valid_in && (is_load || is_store);
  assign bad      = access_bad(is_store, funct3, addr[1:0]);

  // Store lanes are formed from the live inputs at accept; load extension
  // uses the captured fields while the read word arrives.
  lsu_align u_align (
    .st_funct3 (funct3),
    .st_offset (addr[1:0]),
    .st_data   (store_data),
    .st_wstrb  (st_wstrb),
    .st_wdata  (st_wdata),
    .ld_funct3 (f3_q),
    .ld_offset (addr_q[1:0]),
    .ld_rdata  (mem.mem_rdata),
    .ld_data   (ld_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = bad ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem.mem_gnt) begin
          state_d = we_q ? ST_RESP : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem.mem_rvalid) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      f3_q        <= '0;
      rd_q        <= '0;
      we_q        <= 1'b0;
      fault_q     <= 1'b0;
      wstrb_q     <= 4'b0000;
      wdata_q     <= '0;
      load_data_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        f3_q    <= funct3;
        rd_q    <= rd_in;
        fault_q <= bad;
        // A faulting store never reaches memory, so it keeps write fields clear.
        we_q    <= is_store && !bad;
        wstrb_q <= (is_store && !bad) ? st_wstrb : 4'b0000;
        wdata_q <= (is_store && !bad) ? st_wdata : '0;
        if (bad) begin
          load_data_q <= '0;
        end
      end
      // load_data only changes on the cycle the result becomes visible, so it
      // holds the previous result for the whole of the next access.
      if ((state_q == ST_REQ) && mem.mem_gnt && we_q) begin
        load_data_q <= '0;
      end
      if ((state_q == ST_WAIT) && mem.mem_rvalid) begin
        load_data_q <= ld_ext;
      end
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_RESP);
  assign fault     = (state_q == ST_RESP) && fault_q;
  assign load_data = load_data_q;
  assign rd_out    = rd_q;

  assign mem.mem_req   = (state_q == ST_REQ);
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign mem.mem_wdata = wdata_q;
  assign mem.mem_wstrb = wstrb_q;

endmodule
